// File: rtl/phy_rx_lane_ctrl_if.sv
// Byte-stream and lane-steering bundle between the receive byte source
// and the phy_rx lane controller.
interface phy_rx_lane_ctrl_if;
    logic [7:0] data_000;
    logic       valid_000;
    logic       push_00;
    logic       push_11;
    logic       sel;
    logic       active;
    logic [1:0] state;
    logic [3:0] err_cnt;

    // Byte source side: drives the stream, observes the controller.
    modport master (
        output data_000,
        output valid_000,
        input  push_00,
        input  push_11,
        input  sel,
        input  active,
        input  state,
        input  err_cnt
    );

    // Controller side: consumes the stream, produces lane strobes.
    modport slave (
        input  data_000,
        input  valid_000,
        output push_00,
        output push_11,
        output sel,
        output active,
        output state,
        output err_cnt
    );
endinterface

// File: rtl/phy_rx_lane_ctrl.sv
// Receive lane controller: acquires byte alignment from COM characters and
// steers each valid byte alternately to lane 00 / lane 11 of the demux.
// All outputs are registered; strobes line up with the datapath's byte
// register (byte sampled at edge N -> push during cycle N+1).
module phy_rx_lane_ctrl #(
    parameter logic [7:0] COM        = 8'hBC,
    parameter int         SYNC_COUNT = 4,
    parameter int         ERR_LIMIT  = 4
) (
    input  logic               clk_2f,
    input  logic               reset_L,
    phy_rx_lane_ctrl_if.slave  bus
);

    localparam int CW = $clog2(SYNC_COUNT + 1);

    // Last COM count before the one that completes acquisition.
    localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_COUNT - 1);
    localparam logic [3:0]    ERR_LIM_V = 4'(ERR_LIMIT);

    typedef enum logic [1:0] {
        LOSS_SYNC = 2'b00,
        SYNC      = 2'b01,
        ACTIVE    = 2'b10
    } state_t;

    state_t          state_q,   state_d;
    logic [CW-1:0]   com_cnt_q, com_cnt_d;
    logic            sel_q,     sel_d;
    logic [3:0]      err_cnt_q, err_cnt_d;
    logic            push_00_q, push_00_d;
    logic            push_11_q, push_11_d;
    logic            active_q,  active_d;
    logic            is_com_s;

    assign is_com_s = (bus.data_000 == COM);

    // Next-state and strobe decision for the byte presented this cycle.
    always_comb begin
        state_d   = state_q;
        com_cnt_d = com_cnt_q;
        sel_d     = sel_q;
        err_cnt_d = err_cnt_q;
        push_00_d = 1'b0;
        push_11_d = 1'b0;
        if (bus.valid_000) begin
            case (state_q)
                SYNC: begin
                    if (is_com_s) begin
                        state_d = SYNC;
                    end else begin
                        // First data byte after the COM run opens lane 00.
                        state_d   = ACTIVE;
                        push_00_d = 1'b1;
                        sel_d     = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (is_com_s && sel_q) begin
                        if ((err_cnt_q + 4'd1) == ERR_LIM_V) begin
                            // Too many misaligned COMs: drop the byte and resync.
                            state_d   = LOSS_SYNC;
                            sel_d     = 1'b0;
                            com_cnt_d = {CW{1'b0}};
                            err_cnt_d = 4'd0;
                        end else begin
                            err_cnt_d = err_cnt_q + 4'd1;
                            push_11_d = 1'b1;
                            sel_d     = 1'b0;
                        end
                    end else begin
                        if (sel_q) begin
                            push_11_d = 1'b1;
                        end else begin
                            push_00_d = 1'b1;
                        end
                        sel_d = ~sel_q;
                        if (is_com_s) begin
                            err_cnt_d = 4'd0;
                        end else begin
                            err_cnt_d = err_cnt_q;
                        end
                    end
                end
                default: begin
                    // LOSS_SYNC, and the unused encoding behaves the same.
                    if (is_com_s) begin
                        if (com_cnt_q == SYNC_LAST) begin
                            state_d   = SYNC;
                            com_cnt_d = {CW{1'b0}};
                        end else begin
                            state_d   = LOSS_SYNC;
                            com_cnt_d = com_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        state_d   = LOSS_SYNC;
                        com_cnt_d = {CW{1'b0}};
                    end
                end
            endcase
        end else begin
            state_d = state_q;
        end
        active_d = (state_d == ACTIVE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_2f) begin
        if (!reset_L) begin
            state_q   <= LOSS_SYNC;
            com_cnt_q <= {CW{1'b0}};
            sel_q     <= 1'b0;
            err_cnt_q <= 4'd0;
            push_00_q <= 1'b0;
            push_11_q <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            com_cnt_q <= com_cnt_d;
            sel_q     <= sel_d;
            err_cnt_q <= err_cnt_d;
            push_00_q <= push_00_d;
            push_11_q <= push_11_d;
            active_q  <= active_d;
        end
    end

    assign bus.push_00 = push_00_q;
    assign bus.push_11 = push_11_q;
    assign bus.sel     = sel_q;
    assign bus.active  = active_q;
    assign bus.state   = state_q;
    assign bus.err_cnt = err_cnt_q;

endmodule
